c3lib_sync_debounce_edge: RTL and testbench

C3LIB_SYNC_DEBOUNCE_EDGE -- requirements
Module: c3lib_sync_debounce_edge

---
 rtl/c3lib_debounce_pkg.sv | 16 +
 rtl/c3lib_sat_counter.sv | 29 ++
 rtl/c3lib_sync_debounce_edge.sv | 139 +++++++++++++
 tb/tb_c3lib_sync_debounce_edge.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/c3lib_debounce_pkg.sv
// c3lib_debounce_pkg
//   Shared definitions for the debounce/edge-detect block family.
//   - db_state_t        : 2-bit debounce FSM state encoding
//   - MAX_DEBOUNCE_CNT  : largest supported qualify length
package c3lib_debounce_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    QUAL_HI   = 2'd1,
    STABLE_HI = 2'd2,
    QUAL_LO   = 2'd3
  } db_state_t;

  localparam int MAX_DEBOUNCE_CNT = 255;

endpackage : c3lib_debounce_pkg

// File: rtl/c3lib_sat_counter.sv
// c3lib_sat_counter
//   Saturating up-counter with synchronous clear.
//   Ports:
//     clk    : clock, all state updates on posedge
//     rst_n  : synchronous active-low reset, loads 0
//     clr    : synchronous clear; wins over inc on the same edge
//     inc    : add one, holding at all-ones instead of wrapping
//     count  : registered count value
module c3lib_sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule : c3lib_sat_counter

// File: rtl/c3lib_sync_debounce_edge.sv
// c3lib_sync_debounce_edge
//   Debounces an already-synchronized level and reports committed edges.
//   A new level must be seen on DEBOUNCE_CNT consecutive samples before
//   data_out follows it; a candidate that reverts early is counted as a
//   glitch.
//   Parameters:
//     RESET_VAL    : reset level of data_out (0 or 1)
//     DEBOUNCE_CNT : consecutive samples needed to commit (1..255)
//     GCNT_W       : width of glitch_cnt
//   Ports:
//     clk        : single clock, posedge
//     rst_n      : synchronous active-low reset
//     data_in    : synchronized input level
//     clr_glitch : synchronous clear of glitch_cnt
//     data_out   : debounced level (registered)
//     rise_pulse : one-cycle pulse on committed 0->1 (registered)
//     fall_pulse : one-cycle pulse on committed 1->0 (registered)
//     glitch_cnt : saturating count of aborted candidates (registered)
//     state_dbg  : current FSM state, for observation only
module c3lib_sync_debounce_edge
  import c3lib_debounce_pkg::*;
#(
  parameter int RESET_VAL    = 0,
  parameter int DEBOUNCE_CNT = 4,
  parameter int GCNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              data_in,
  input  logic              clr_glitch,
  output logic              data_out,
  output logic              rise_pulse,
  output logic              fall_pulse,
  output logic [GCNT_W-1:0] glitch_cnt,
  output db_state_t         state_dbg
);

  if ((DEBOUNCE_CNT < 1) || (DEBOUNCE_CNT > MAX_DEBOUNCE_CNT)) begin : g_bad_cnt
    $error("c3lib_sync_debounce_edge: DEBOUNCE_CNT out of range");
  end

  localparam int             CW        = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [CW:0]    CNT_LAST  = (CW + 1)'(DEBOUNCE_CNT);
  localparam logic           RST_LVL   = (RESET_VAL != 0);
  localparam db_state_t      RST_STATE = RST_LVL ? STABLE_HI : STABLE_LO;

  db_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW:0]   cnt_inc;
  logic          data_q, data_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic          glitch_inc;

  // State, counter and all outputs are registered together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
      data_q  <= RST_LVL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // The candidate level is always the complement of data_q, so data_q
  // alone decides the direction of a commit or a revert.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    rise_d     = 1'b0;
    fall_d     = 1'b0;
    glitch_inc = 1'b0;
    cnt_inc    = {1'b0, cnt_q} + (CW + 1)'(1);

    case (state_q)
      STABLE_LO, STABLE_HI: begin
        if (data_in != data_q) begin
          if (DEBOUNCE_CNT == 1) begin
            // Single-sample qualify: commit straight away.
            data_d  = ~data_q;
            rise_d  = ~data_q;
            fall_d  = data_q;
            state_d = data_q ? STABLE_LO : STABLE_HI;
            cnt_d   = '0;
          end else begin
            state_d = data_q ? QUAL_LO : QUAL_HI;
            cnt_d   = CW'(1);
          end
        end
      end

      QUAL_HI, QUAL_LO: begin
        if (data_in == data_q) begin
          // Candidate abandoned before qualifying.
          state_d    = data_q ? STABLE_HI : STABLE_LO;
          cnt_d      = '0;
          glitch_inc = 1'b1;
        end else if (cnt_inc == CNT_LAST) begin
          data_d  = ~data_q;
          rise_d  = ~data_q;
          fall_d  = data_q;
          state_d = data_q ? STABLE_LO : STABLE_HI;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc[CW-1:0];
        end
      end

      default: begin
        state_d = data_q ? STABLE_HI : STABLE_LO;
        cnt_d   = '0;
      end
    endcase
  end

  c3lib_sat_counter #(
    .WIDTH (GCNT_W)
  ) u_glitch_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_glitch),
    .inc   (glitch_inc),
    .count (glitch_cnt)
  );

  assign data_out   = data_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign state_dbg  = state_q;

endmodule : c3lib_sync_debounce_edge

// File: tb/tb_c3lib_sync_debounce_edge.sv
// Directed bench for c3lib_sync_debounce_edge using four instances:
//   a: DEBOUNCE_CNT=4 (defaults)    b: DEBOUNCE_CNT=1
//   c: DEBOUNCE_CNT=4, GCNT_W=2     d: RESET_VAL=1, DEBOUNCE_CNT=4
module tb_c3lib_sync_debounce_edge;
  import c3lib_debounce_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic a_din, b_din, c_din, d_din;
  logic c_clr;

  logic       a_out, a_rise, a_fall; logic [7:0] a_gc; db_state_t a_st;
  logic       b_out, b_rise, b_fall; logic [7:0] b_gc; db_state_t b_st;
  logic       c_out, c_rise, c_fall; logic [1:0] c_gc; db_state_t c_st;
  logic       d_out, d_rise, d_fall; logic [7:0] d_gc; db_state_t d_st;

  c3lib_sync_debounce_edge #(.RESET_VAL(0), .DEBOUNCE_CNT(4), .GCNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .data_in(a_din), .clr_glitch(1'b0),
    .data_out(a_out), .rise_pulse(a_rise), .fall_pulse(a_fall),
    .glitch_cnt(a_gc), .state_dbg(a_st));

  c3lib_sync_debounce_edge #(.RESET_VAL(0), .DEBOUNCE_CNT(1), .GCNT_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .data_in(b_din), .clr_glitch(1'b0),
    .data_out(b_out), .rise_pulse(b_rise), .fall_pulse(b_fall),
    .glitch_cnt(b_gc), .state_dbg(b_st));

  c3lib_sync_debounce_edge #(.RESET_VAL(0), .DEBOUNCE_CNT(4), .GCNT_W(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .data_in(c_din), .clr_glitch(c_clr),
    .data_out(c_out), .rise_pulse(c_rise), .fall_pulse(c_fall),
    .glitch_cnt(c_gc), .state_dbg(c_st));

  c3lib_sync_debounce_edge #(.RESET_VAL(1), .DEBOUNCE_CNT(4), .GCNT_W(8)) dut_d (
    .clk(clk), .rst_n(rst_n), .data_in(d_din), .clr_glitch(1'b0),
    .data_out(d_out), .rise_pulse(d_rise), .fall_pulse(d_fall),
    .glitch_cnt(d_gc), .state_dbg(d_st));

  // ---------------- driver / checker tasks ----------------
  int checks   = 0;
  int failures = 0;

  // Advance past one active edge; outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0;
    a_din = 1'b0; b_din = 1'b0; c_din = 1'b0; d_din = 1'b1;
    c_clr = 1'b0;
    step();
    step();

    // Reset state
    check("a_rst_out",   32'(a_out), 32'd0);
    check("a_rst_rise",  32'(a_rise), 32'd0);
    check("a_rst_fall",  32'(a_fall), 32'd0);
    check("a_rst_gc",    32'(a_gc), 32'd0);
    check("a_rst_state", 32'(a_st), 32'(STABLE_LO));
    check("d_rst_out",   32'(d_out), 32'd1);
    check("d_rst_state", 32'(d_st), 32'(STABLE_HI));

    rst_n = 1'b1;
    step();
    check("a_idle_state", 32'(a_st), 32'(STABLE_LO));
    check("d_idle_state", 32'(d_st), 32'(STABLE_HI));

    // a: 0->1 held; first high sample at edge k, commit at k+3
    a_din = 1'b1;
    step();                                   // edge k
    check("a_k0_out",   32'(a_out), 32'd0);
    check("a_k0_state", 32'(a_st), 32'(QUAL_HI));
    step();                                   // k+1
    check("a_k1_out",   32'(a_out), 32'd0);
    step();                                   // k+2
    check("a_k2_out",   32'(a_out), 32'd0);
    check("a_k2_rise",  32'(a_rise), 32'd0);
    step();                                   // k+3
    check("a_k3_out",   32'(a_out), 32'd1);
    check("a_k3_rise",  32'(a_rise), 32'd1);
    check("a_k3_fall",  32'(a_fall), 32'd0);
    check("a_k3_state", 32'(a_st), 32'(STABLE_HI));
    for (int i = 0; i < 6; i++) begin
      step();
      check("a_hold_out",  32'(a_out), 32'd1);
      check("a_hold_rise", 32'(a_rise), 32'd0);
      check("a_hold_fall", 32'(a_fall), 32'd0);
    end
    check("a_hold_gc", 32'(a_gc), 32'd0);

    // a: 1->0 held; fall commits on the fourth low sample
    a_din = 1'b0;
    step();
    check("a_f0_state", 32'(a_st), 32'(QUAL_LO));
    step();
    step();
    check("a_f2_out",   32'(a_out), 32'd1);
    step();
    check("a_f3_out",   32'(a_out), 32'd0);
    check("a_f3_fall",  32'(a_fall), 32'd1);
    check("a_f3_rise",  32'(a_rise), 32'd0);
    step();
    check("a_f4_fall",  32'(a_fall), 32'd0);

    // a: high for two samples then low -> glitch
    a_din = 1'b1;
    step();
    step();
    check("a_g_qual_out", 32'(a_out), 32'd0);
    a_din = 1'b0;
    step();
    check("a_g_out",   32'(a_out), 32'd0);
    check("a_g_rise",  32'(a_rise), 32'd0);
    check("a_g_state", 32'(a_st), 32'(STABLE_LO));
    check("a_g_gc",    32'(a_gc), 32'd1);
    step();
    check("a_g_rise2", 32'(a_rise), 32'd0);

    // b: DEBOUNCE_CNT=1, toggling input followed one edge later
    for (int i = 0; i < 4; i++) begin
      b_din = 1'b1;
      step();
      check("b_tog_out1",  32'(b_out), 32'd1);
      check("b_tog_rise1", 32'(b_rise), 32'd1);
      check("b_tog_fall1", 32'(b_fall), 32'd0);
      b_din = 1'b0;
      step();
      check("b_tog_out0",  32'(b_out), 32'd0);
      check("b_tog_rise0", 32'(b_rise), 32'd0);
      check("b_tog_fall0", 32'(b_fall), 32'd1);
    end
    step();
    check("b_end_fall", 32'(b_fall), 32'd0);
    check("b_end_gc",   32'(b_gc), 32'd0);

    // c: five glitches saturate a 2-bit counter at 3
    for (int n = 1; n <= 5; n++) begin
      c_din = 1'b1;
      step();
      c_din = 1'b0;
      step();
      check("c_sat_gc", 32'(c_gc), (n < 3) ? 32'(n) : 32'd3);
      check("c_sat_out", 32'(c_out), 32'd0);
    end
    // Sixth glitch coincident with clear: clear wins
    c_din = 1'b1;
    step();
    c_din = 1'b0;
    c_clr = 1'b1;
    step();
    c_clr = 1'b0;
    check("c_clr_gc", 32'(c_gc), 32'd0);

    // d: one QUAL_LO glitch, then reset while qualifying at count 2
    d_din = 1'b0;
    step();
    check("d_q_state", 32'(d_st), 32'(QUAL_LO));
    d_din = 1'b1;
    step();
    check("d_g_state", 32'(d_st), 32'(STABLE_HI));
    check("d_g_gc",    32'(d_gc), 32'd1);
    check("d_g_fall",  32'(d_fall), 32'd0);
    d_din = 1'b0;
    step();
    step();
    check("d_q2_state", 32'(d_st), 32'(QUAL_LO));
    check("d_q2_out",   32'(d_out), 32'd1);
    rst_n = 1'b0;
    step();
    check("d_rq_out",   32'(d_out), 32'd1);
    check("d_rq_fall",  32'(d_fall), 32'd0);
    check("d_rq_state", 32'(d_st), 32'(STABLE_HI));
    check("d_rq_gc",    32'(d_gc), 32'd0);
    check("a_rq_gc",    32'(a_gc), 32'd0);
    rst_n = 1'b1;
    step();
    // First sample after reset is still low -> new qualify starts
    check("d_post_state", 32'(d_st), 32'(QUAL_LO));
    check("d_post_out",   32'(d_out), 32'd1);
    check("d_post_gc",    32'(d_gc), 32'd0);
    check("a_post_state", 32'(a_st), 32'(STABLE_LO));

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_c3lib_sync_debounce_edge
